// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO-to-word byte packer.
package fifo_pkg;

  localparam int LANES_DEF = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Pops bytes from an upstream FIFO and packs them little-endian into LANES-byte
// words with a keep mask; flush closes a partial word early.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         fifo_dout,
  input  logic               fifo_empty,
  output logic               fifo_read,
  input  logic               flush,
  output logic [8*LANES-1:0] m_data,
  output logic [LANES-1:0]   m_keep,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CNT_W-1:0]   word_cnt
);

  localparam int IDX_W = $clog2(LANES);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             pop, last, close, accept;

  assign pop       = (state == COLLECT) && !fifo_empty && !rst;
  assign fifo_read = pop;
  assign last      = (idx == IDX_W'(LANES - 1));
  // A flush with nothing packed and nothing popping would make an empty word.
  assign close     = (state == COLLECT) && (pop ? (last || flush) : (flush && idx != '0));
  assign accept    = (state == SEND) && m_ready;
  assign m_valid   = (state == SEND);

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (close)   state_nxt = SEND;
      SEND:    if (m_ready) state_nxt = COLLECT;
      default:              state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      m_data   <= '0;
      m_keep   <= '0;
      word_cnt <= '0;
    end else begin
      if (pop) begin
        m_data[8*idx +: 8] <= fifo_dout;
        m_keep[idx]        <= 1'b1;
      end
      if (close)    idx <= '0;
      else if (pop) idx <= idx + 1'b1;
      if (accept) begin
        m_data <= '0;
        m_keep <= '0;
        if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_read_empty: assert property (@(posedge clk) fifo_empty |-> !fifo_read);
  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    m_valid && !m_ready |=> $stable(m_data) && $stable(m_keep) && m_valid);
  a_keep_nonzero: assert property (@(posedge clk) disable iff (rst)
    m_valid |-> m_keep != '0);
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed and random scenarios for fifo_word_packer with a byte-source model
// and a word scoreboard filled as bytes are popped.
module tb_fifo_word_packer;

  localparam int L  = 4;
  localparam int CW = 4;

  typedef struct {
    logic [8*L-1:0] data;
    logic [L-1:0]   keep;
  } word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    fifo_dout;
  logic          fifo_empty;
  logic          fifo_read;
  logic          flush;
  logic [8*L-1:0] m_data;
  logic [L-1:0]  m_keep;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] word_cnt;

  fifo_word_packer #(.LANES(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read), .flush(flush), .m_data(m_data), .m_keep(m_keep),
    .m_valid(m_valid), .m_ready(m_ready), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] src_q[$];
  word_t      exp_q[$];
  logic       gate;

  // Reference state
  logic           msend;
  int             midx;
  logic [8*L-1:0] mdata;
  logic [L-1:0]   mkeep;
  logic [CW-1:0]  mcnt;

  int             pops, valid_cycles;
  logic [8*L-1:0] last_data;
  logic [L-1:0]   last_keep;
  int             checks, errors;

  task automatic refresh();
    fifo_empty = gate || (src_q.size() == 0);
    fifo_dout  = (src_q.size() != 0) ? src_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    src_q.push_back(b);
  endtask

  // One clock: check at negedge, advance the model, feed the next head byte.
  task automatic step();
    logic  exp_read, pop, acc;
    word_t w;
    @(negedge clk);
    exp_read = !rst && !msend && !fifo_empty;
    checks++;
    if (fifo_read !== exp_read) begin
      errors++; $display("FAIL fifo_read got %b want %b t=%0t", fifo_read, exp_read, $time);
    end
    checks++;
    if (m_valid !== msend) begin
      errors++; $display("FAIL m_valid got %b want %b t=%0t", m_valid, msend, $time);
    end
    checks++;
    if (word_cnt !== mcnt) begin
      errors++; $display("FAIL word_cnt got %0d want %0d t=%0t", word_cnt, mcnt, $time);
    end
    if (msend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty got valid word %h want none", m_data);
      end else if (m_data !== exp_q[0].data || m_keep !== exp_q[0].keep) begin
        errors++;
        $display("FAIL word got %h/%b want %h/%b t=%0t", m_data, m_keep,
                 exp_q[0].data, exp_q[0].keep, $time);
      end
    end
    if (m_valid === 1'b1) valid_cycles++;
    pop = exp_read;
    acc = !rst && msend && m_ready;
    if (pop) pops++;
    if (rst) begin
      msend = 1'b0; midx = 0; mdata = '0; mkeep = '0; mcnt = '0;
      exp_q.delete();
    end else if (!msend) begin
      if (pop) begin
        mdata[8*midx +: 8] = fifo_dout;
        mkeep[midx] = 1'b1;
      end
      if ((pop && (midx == L-1 || flush)) || (!pop && flush && midx != 0)) begin
        w.data = mdata; w.keep = mkeep;
        exp_q.push_back(w);
        msend = 1'b1; midx = 0;
      end else if (pop) begin
        midx++;
      end
    end else if (acc) begin
      last_data = m_data; last_keep = m_keep;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      msend = 1'b0; mdata = '0; mkeep = '0;
      if (mcnt != '1) mcnt++;
    end
    @(posedge clk);
    #1;
    if (pop && src_q.size() != 0) void'(src_q.pop_front());
    refresh();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b1; flush = 1'b0; gate = 1'b0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    refresh();
    run(2);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", m_valid); end
    checks++; if (m_keep !== '0) begin errors++; $display("FAIL rst_keep got %b want 0", m_keep); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL rst_data got %h want 0", m_data); end
    checks++; if (word_cnt !== '0) begin errors++; $display("FAIL rst_cnt got %0d want 0", word_cnt); end
    rst = 1'b0; pops = 0; valid_cycles = 0;
    run(6);
    checks++; if (pops != 4) begin errors++; $display("FAIL full_pops got %0d want 4", pops); end
    checks++; if (valid_cycles != 1) begin errors++; $display("FAIL full_valid_cycles got %0d want 1", valid_cycles); end
    checks++; if (last_data !== 32'h44332211) begin errors++; $display("FAIL full_data got %h want 44332211", last_data); end
    checks++; if (last_keep !== 4'hF) begin errors++; $display("FAIL full_keep got %b want 1111", last_keep); end
    checks++; if (word_cnt !== 4'd1) begin errors++; $display("FAIL full_cnt got %0d want 1", word_cnt); end
  endtask

  task automatic test_flush_partial();
    m_ready = 1'b0;
    push(8'hAA); push(8'hBB); refresh();
    run(2);
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL pflush_valid got %b want 1", m_valid); end
    checks++; if (m_data !== 32'h0000BBAA) begin errors++; $display("FAIL pflush_data got %h want 0000bbaa", m_data); end
    checks++; if (m_keep !== 4'b0011) begin errors++; $display("FAIL pflush_keep got %b want 0011", m_keep); end
    m_ready = 1'b1; step();
    checks++; if (word_cnt !== 4'd2) begin errors++; $display("FAIL pflush_cnt got %0d want 2", word_cnt); end
  endtask

  task automatic test_hold();
    int n;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    refresh();
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (m_valid !== 1'b1) begin
      errors++; $display("FAIL hold_timeout got valid %b want 1 within 20 cycles", m_valid);
    end
    for (int i = 0; i < 10; i++) begin
      flush = (i == 3);
      step();
      checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL hold_read got %b want 0", fifo_read); end
      checks++; if (m_data !== 32'h04030201) begin errors++; $display("FAIL hold_data got %h want 04030201", m_data); end
    end
    flush = 1'b0; m_ready = 1'b1;
    step();
    checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL hold_resume got %b want 1", fifo_read); end
    run(6);
    checks++; if (last_data !== 32'h08070605) begin errors++; $display("FAIL hold_next_data got %h want 08070605", last_data); end
    checks++; if (last_keep !== 4'hF) begin errors++; $display("FAIL hold_next_keep got %b want 1111", last_keep); end
  endtask

  task automatic test_flush_idx0();
    valid_cycles = 0;
    flush = 1'b1; run(2); flush = 1'b0;
    checks++; if (valid_cycles != 0 || m_valid !== 1'b0) begin errors++; $display("FAIL idle_flush_valid got %0d want 0", valid_cycles); end
    m_ready = 1'b0;
    push(8'h5A); refresh();
    flush = 1'b1; step(); flush = 1'b0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL pop_flush_valid got %b want 1", m_valid); end
    checks++; if (m_keep !== 4'b0001) begin errors++; $display("FAIL pop_flush_keep got %b want 0001", m_keep); end
    checks++; if (m_data[7:0] !== 8'h5A) begin errors++; $display("FAIL pop_flush_data got %h want 5a", m_data[7:0]); end
    m_ready = 1'b1; step();
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    push(8'hC1); push(8'hC2); refresh();
    run(2);
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", m_valid); end
    checks++; if (m_keep !== '0) begin errors++; $display("FAIL mid_rst_keep got %b want 0", m_keep); end
    checks++; if (word_cnt !== '0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", word_cnt); end
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4); refresh();
    run(6);
    checks++; if (last_data !== 32'hD4D3D2D1) begin errors++; $display("FAIL mid_rst_word got %h want d4d3d2d1", last_data); end
    checks++; if (word_cnt !== 4'd1) begin errors++; $display("FAIL mid_rst_cnt2 got %0d want 1", word_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] c0;
    m_ready = 1'b1; c0 = word_cnt;
    for (int i = 0; i < 16; i++) push(8'($urandom));
    refresh();
    run(20);
    checks++; if (word_cnt - c0 !== CW'(4)) begin errors++; $display("FAIL b2b_words got %0d want 4", word_cnt - c0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) push(8'($urandom));
    refresh();
    for (int i = 0; i < 300; i++) begin
      m_ready = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 9) == 0);
      gate    = ($urandom_range(0, 9) < 2);
      step();
    end
    gate = 1'b0; flush = 1'b0; m_ready = 1'b1;
    run(200);
    flush = 1'b1; step(); flush = 1'b0;
    run(3);
    checks++; if (exp_q.size() != 0 || src_q.size() != 0) begin
      errors++; $display("FAIL rand_drain got %0d/%0d want 0/0", exp_q.size(), src_q.size());
    end
  endtask

  task automatic test_saturation();
    m_ready = 1'b1;
    for (int i = 0; i < 4*20; i++) push(8'($urandom));
    refresh();
    run(20*5 + 5);
    checks++; if (word_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt got %0d want 15", word_cnt); end
  endtask

  initial begin
    checks = 0; errors = 0; pops = 0; valid_cycles = 0;
    msend = 1'b0; midx = 0; mdata = '0; mkeep = '0; mcnt = '0;
    last_data = '0; last_keep = '0;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; gate = 1'b0;
    refresh();
    @(posedge clk); #1;
    test_reset();
    test_flush_partial();
    test_hold();
    test_flush_idx0();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
